// File: rtl/mem_ctrl_if.sv
// Memory controller bus: fetch port, load/store port and RAM/UART side.
// mem_ctrl binds the slave view; requesters and RAM sit on the master view.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_en;
  logic [ADDR_W-1:0] if_pc;
  logic              if_done;
  logic [31:0]       if_data;
  logic              lsb_en;
  logic              lsb_wr;
  logic [ADDR_W-1:0] lsb_a;
  logic [2:0]        lsb_l;
  logic [31:0]       lsb_w;
  logic              lsb_done;
  logic [31:0]       lsb_r;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport slave (
    input  if_en, if_pc, lsb_en, lsb_wr,
    input  lsb_a, lsb_l, lsb_w,
    input  mem_din, io_buffer_full,
    output if_done, if_data, lsb_done, lsb_r,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_en, if_pc, lsb_en, lsb_wr,
    output lsb_a, lsb_l, lsb_w,
    output mem_din, io_buffer_full,
    input  if_done, if_data, lsb_done, lsb_r,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and
// load/store traffic onto a single-port RAM with UART back-pressure.
module mem_ctrl #(
  parameter int         ADDR_W  = 32,
  parameter logic [1:0] IO_ADDR = 2'b11
) (
  input logic      clk,
  input logic      rst,
  input logic      rdy,
  input logic      rollback,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [2:0]        cnt, cnt_nx;
  logic [2:0]        len, len_nx;
  logic [ADDR_W-1:0] base, base_nx;
  logic [31:0]       data, data_nx;
  logic              is_lsb, is_lsb_nx;
  logic              last_lsb, last_nx;
  logic              stale, stale_nx;
  logic              if_done, if_done_nx;
  logic              lsb_done, lsb_done_nx;
  logic [31:0]       if_data, if_data_nx;
  logic [31:0]       lsb_r, lsb_r_nx;

  logic       if_req, lsb_req;
  logic       grant_if, grant_lsb;
  logic       io_stall, abort;
  logic [2:0] cnt_inc;
  logic [4:0] wr_idx, rd_idx;

  assign bus.if_done  = if_done;
  assign bus.lsb_done = lsb_done;
  assign bus.if_data  = if_data;
  assign bus.lsb_r    = lsb_r;

  // A requester whose done is still high is finishing, not asking again.
  assign if_req  = bus.if_en && !bus.if_done && !rollback;
  assign lsb_req = bus.lsb_en && !bus.lsb_done;

  assign grant_lsb = lsb_req && (!if_req || !last_lsb);
  assign grant_if  = if_req && !grant_lsb;

  assign io_stall = bus.io_buffer_full
                 && (base[17:16] == IO_ADDR);
  assign abort    = rollback && !is_lsb
                 && (state == READ);

  assign cnt_inc = cnt + 3'd1;
  assign wr_idx  = {cnt[1:0], 3'b000};
  assign rd_idx  = {cnt[1:0] - 2'd1, 3'b000};

  always_comb begin
    bus.mem_a    = '0;
    bus.mem_dout = '0;
    bus.mem_wr   = 1'b0;
    unique case (state)
      READ: begin
        if (stale)
          bus.mem_a = base + ADDR_W'(cnt - 3'd1);
        else
          bus.mem_a = base + ADDR_W'(cnt);
      end
      WRITE: begin
        bus.mem_a    = base + ADDR_W'(cnt);
        bus.mem_dout = data[wr_idx +: 8];
        bus.mem_wr   = rdy && !rst && !io_stall;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    len_nx      = len;
    base_nx     = base;
    data_nx     = data;
    is_lsb_nx   = is_lsb;
    last_nx     = last_lsb;
    stale_nx    = stale;
    if_done_nx  = 1'b0;
    lsb_done_nx = 1'b0;
    if_data_nx  = if_data;
    lsb_r_nx    = lsb_r;
    unique case (state)
      IDLE: begin
        cnt_nx   = '0;
        stale_nx = 1'b0;
        if (grant_lsb) begin
          state_nx  = bus.lsb_wr ? WRITE : READ;
          base_nx   = bus.lsb_a;
          len_nx    = bus.lsb_l;
          is_lsb_nx = 1'b1;
          last_nx   = 1'b1;
          data_nx   = bus.lsb_wr ? bus.lsb_w : '0;
        end else if (grant_if) begin
          state_nx  = READ;
          base_nx   = bus.if_pc;
          len_nx    = 3'd4;
          is_lsb_nx = 1'b0;
          last_nx   = 1'b0;
          data_nx   = '0;
        end
      end
      READ: begin
        if (abort) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          stale_nx = 1'b0;
        end else if (stale) begin
          stale_nx = 1'b0;
        end else begin
          // mem_din carries the byte addressed last cycle
          if (cnt != 3'd0)
            data_nx[rd_idx +: 8] = bus.mem_din;
          if (cnt == len) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            if (is_lsb) begin
              lsb_done_nx = 1'b1;
              lsb_r_nx    = data_nx;
            end else begin
              if_done_nx = 1'b1;
              if_data_nx = data_nx;
            end
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      end
      WRITE: begin
        if (!io_stall) begin
          if (cnt_inc >= len) begin
            state_nx    = IDLE;
            cnt_nx      = '0;
            lsb_done_nx = 1'b1;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      len      <= '0;
      base     <= '0;
      data     <= '0;
      is_lsb   <= 1'b0;
      last_lsb <= 1'b0;
      stale    <= 1'b0;
      if_done  <= 1'b0;
      lsb_done <= 1'b0;
      if_data  <= '0;
      lsb_r    <= '0;
    end else if (rdy) begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      len      <= len_nx;
      base     <= base_nx;
      data     <= data_nx;
      is_lsb   <= is_lsb_nx;
      last_lsb <= last_nx;
      stale    <= stale_nx;
      if_done  <= if_done_nx;
      lsb_done <= lsb_done_nx;
      if_data  <= if_data_nx;
      lsb_r    <= lsb_r_nx;
    end else if (state == READ && cnt != 3'd0) begin
      // RAM kept reading during the freeze; re-address before capture
      stale <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: synchronous RAM model, transaction
// scoreboard checked every cycle, plus literal expectations.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst, rdy, rollback;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(32)) bus();

  mem_ctrl #(.ADDR_W(32), .IO_ADDR(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rollback(rollback), .bus(bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  int n_chk = 0;
  int n_fail = 0;

  bit [7:0] ram     [0:262143];
  bit       ram_set [0:262143];
  bit [7:0] shadow  [0:262143];
  bit       sh_set  [0:262143];

  wr_t         wq[$];
  logic [31:0] ifq[$];
  logic [31:0] lsbq[$];
  logic [31:0] alog[$];
  int          order[$];
  bit          seen_if, seen_lsb, prev_if, prev_lsb;
  int          if_at, wr_cnt;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102, 32'h103: return 8'h00;
      default: return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram_set[a[17:0]] ? ram[a[17:0]] : init_byte(a);
  endfunction

  function automatic logic [7:0] mread(input logic [31:0] a);
    return sh_set[a[17:0]] ? shadow[a[17:0]] : init_byte(a);
  endfunction

  // synchronous RAM: data appears one cycle after its address
  always @(posedge clk) begin
    if (bus.mem_wr) begin
      ram[bus.mem_a[17:0]]     <= bus.mem_dout;
      ram_set[bus.mem_a[17:0]] <= 1'b1;
    end
    bus.mem_din <= ram_rd(bus.mem_a);
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_cycle();
    wr_t e;
    alog.push_back(bus.mem_a);
    if (!rdy) chk("stall_no_wr", bus.mem_wr, 0);
    if (bus.mem_wr) begin
      wr_cnt++;
      chk("io_hold", bus.io_buffer_full
          && bus.mem_a[17:16] == 2'b11, 0);
      if (wq.size() == 0) begin
        chk("wr_pending", wq.size() != 0, 1);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", bus.mem_a, e.a);
        chk("wr_data", bus.mem_dout, e.d);
      end
    end
    if (bus.if_done) begin
      seen_if = 1;
      if_at = alog.size() - 1;
      order.push_back(0);
      chk("if_pulse", prev_if, 0);
      if (ifq.size() == 0)
        chk("if_pending", ifq.size() != 0, 1);
      else
        chk("if_data", bus.if_data, ifq.pop_front());
    end
    if (bus.lsb_done) begin
      seen_lsb = 1;
      order.push_back(1);
      chk("lsb_pulse", prev_lsb, 0);
      if (lsbq.size() == 0)
        chk("lsb_pending", lsbq.size() != 0, 1);
      else
        chk("lsb_r", bus.lsb_r, lsbq.pop_front());
    end
    prev_if  = bus.if_done;
    prev_lsb = bus.lsb_done;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_if(input logic [31:0] pc, input bit expect_done);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = mread(pc + i);
    bus.if_en = 1;
    bus.if_pc = pc;
    if (expect_done) ifq.push_back(v);
  endtask

  task automatic issue_lsb(input logic wr, input logic [31:0] a,
                           input logic [2:0] l, input logic [31:0] w,
                           input int nexp);
    logic [31:0] v;
    wr_t e;
    logic [31:0] ai;
    v = '0;
    if (wr) begin
      for (int i = 0; i < nexp; i++) begin
        ai = a + i;
        e.a = ai;
        e.d = w[8*i +: 8];
        wq.push_back(e);
        shadow[ai[17:0]] = e.d;
        sh_set[ai[17:0]] = 1;
      end
      if (nexp == int'(l)) lsbq.push_back(lsb_r_hold());
    end else begin
      for (int i = 0; i < int'(l); i++) v[8*i +: 8] = mread(a + i);
      lsbq.push_back(v);
    end
    bus.lsb_en = 1;
    bus.lsb_wr = wr;
    bus.lsb_a  = a;
    bus.lsb_l  = l;
    bus.lsb_w  = w;
  endtask

  // a store leaves the load-data output at its previous value
  logic [31:0] last_r = '0;
  function automatic logic [31:0] lsb_r_hold();
    return last_r;
  endfunction

  task automatic wait_done(input int sel, input int budget);
    int n;
    n = 0;
    if (sel == 0) seen_if = 0;
    else seen_lsb = 0;
    while ((sel == 0 ? !seen_if : !seen_lsb) && n < budget) begin
      step();
      n++;
    end
    if (sel == 0) begin
      chk("if_timeout", seen_if, 1);
      bus.if_en = 0;
    end else begin
      chk("lsb_timeout", seen_lsb, 1);
      bus.lsb_en = 0;
      if (!bus.lsb_wr) last_r = bus.lsb_r;
    end
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
    last_r = '0;
  endtask

  initial begin
    int b, snap;
    rst = 1; rdy = 0; rollback = 0;
    bus.if_en = 0; bus.if_pc = 0;
    bus.lsb_en = 0; bus.lsb_wr = 0; bus.lsb_a = 0;
    bus.lsb_l = 0; bus.lsb_w = 0; bus.io_buffer_full = 0;
    @(posedge clk); #1;
    step(); step();
    rst = 0; rdy = 1;
    chk("rst_if_done", bus.if_done, 0);
    chk("rst_lsb_done", bus.lsb_done, 0);
    chk("rst_if_data", bus.if_data, 0);
    chk("rst_lsb_r", bus.lsb_r, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_mem_dout", bus.mem_dout, 0);

    // fetch of 0x100
    b = alog.size();
    issue_if(32'h100, 1);
    wait_done(0, 20);
    chk("f_a0", alog[b+1], 32'h100);
    chk("f_a1", alog[b+2], 32'h101);
    chk("f_a2", alog[b+3], 32'h102);
    chk("f_a3", alog[b+4], 32'h103);
    chk("f_lat", if_at - b, 6);
    chk("f_data", bus.if_data, 32'h00000513);

    // tie from reset: LSB wins; rollback drops the IF grant
    do_reset();
    seen_lsb = 0; seen_if = 0;
    bus.if_en = 1; bus.if_pc = 32'h200;
    issue_lsb(0, 32'h300, 3'd4, 0, 0);
    repeat (6) step();
    rollback = 1;
    step();
    rollback = 0; bus.lsb_en = 0; bus.if_en = 0;
    last_r = bus.lsb_r;
    chk("t1_lsb_first", seen_lsb, 1);
    b = alog.size();
    step();
    chk("t1_if_dropped", alog[b], 0);
    repeat (6) step();
    chk("t1_no_if", seen_if, 0);

    // repeated tie: IF first this time
    order.delete();
    issue_if(32'h200, 1);
    issue_lsb(0, 32'h300, 3'd4, 0, 0);
    wait_done(0, 30);
    wait_done(1, 30);
    chk("t2_n", order.size(), 2);
    chk("t2_first_if", order[0], 0);
    chk("t2_then_lsb", order[1], 1);

    // byte store to UART region under back-pressure
    bus.io_buffer_full = 1;
    snap = wr_cnt;
    issue_lsb(1, 32'h30000, 3'd1, 32'h41, 1);
    repeat (3) step();
    chk("io_held", wr_cnt - snap, 0);
    bus.io_buffer_full = 0;
    wait_done(1, 20);
    chk("io_one_wr", wr_cnt - snap, 1);

    // non-IO word store ignores the UART flag
    bus.io_buffer_full = 1;
    snap = wr_cnt;
    issue_lsb(1, 32'h1000, 3'd4, 32'hDEADBEEF, 4);
    wait_done(1, 20);
    chk("sw_four_wr", wr_cnt - snap, 4);
    bus.io_buffer_full = 0;
    issue_lsb(0, 32'h1000, 3'd4, 0, 0);
    wait_done(1, 20);
    chk("lw_back", bus.lsb_r, 32'hDEADBEEF);

    // rollback in 2nd byte of a fetch
    seen_if = 0;
    issue_if(32'h100, 0);
    step(); step();
    rollback = 1;
    step();
    rollback = 0; bus.if_en = 0;
    b = alog.size();
    step();
    chk("rb_idle", alog[b], 0);
    repeat (6) step();
    chk("rb_no_if", seen_if, 0);

    // rollback does not disturb a load
    issue_lsb(0, 32'h100, 3'd4, 0, 0);
    step(); step();
    rollback = 1;
    step();
    rollback = 0;
    wait_done(1, 20);
    chk("rb_lsb_r", bus.lsb_r, 32'h00000513);

    // halfword load wrapping the address space
    b = alog.size();
    issue_lsb(0, 32'hFFFFFFFF, 3'd2, 0, 0);
    wait_done(1, 20);
    chk("lh_a0", alog[b+1], 32'hFFFFFFFF);
    chk("lh_a1", alog[b+2], 32'h0);
    chk("lh_r", bus.lsb_r, 32'h0000A55A);

    issue_lsb(0, 32'h2003, 3'd1, 0, 0);
    wait_done(1, 20);
    chk("lb_r", bus.lsb_r, 32'h000000A6);

    // rdy freeze mid-load and mid-store
    issue_lsb(0, 32'h2000, 3'd4, 0, 0);
    repeat (3) step();
    rdy = 0;
    step(); step();
    rdy = 1;
    wait_done(1, 20);
    issue_lsb(1, 32'h2100, 3'd2, 32'hBEEF, 2);
    step(); step();
    rdy = 0;
    step(); step();
    rdy = 1;
    wait_done(1, 20);
    issue_lsb(0, 32'h2100, 3'd2, 0, 0);
    wait_done(1, 20);
    chk("sh_back", bus.lsb_r, 32'h0000BEEF);

    // reset in the middle of a word store
    seen_lsb = 0;
    issue_lsb(1, 32'h4000, 3'd4, 32'h11223344, 2);
    repeat (3) step();
    snap = wr_cnt;
    rst = 1;
    step();
    rst = 0; bus.lsb_en = 0;
    b = alog.size();
    step();
    chk("rst_idle", alog[b], 0);
    repeat (5) step();
    chk("rst_no_wr", wr_cnt - snap, 0);
    chk("rst_no_done", seen_lsb, 0);

    chk("wq_empty", wq.size(), 0);
    chk("ifq_empty", ifq.size(), 0);
    chk("lsbq_empty", lsbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
